cla_pipe_adder: RTL

- Parametrised, pipelined carry-lookahead add/subtract unit; successor to the team's 4-bit combinational CLA.
- Operand width is split into 4-bit lookahead groups. One group is resolved per pipeline stage, and the group carry is registered between stages.
- Valid/ready streaming interface on input and output; sits between operand-fetch logic and the ALU result bus.
- Also produces carry, signed-overflow and zero flags.

---
 rtl/cla_pkg.sv | 24 ++
 rtl/cla_pipe_adder_if.sv | 36 +++
 rtl/cla_group4.sv | 21 ++
 rtl/cla_pipe_adder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared lookahead types and carry function for the pipelined CLA adder
package cla_pkg;

    localparam int CLA_GRP_W = 4;

    typedef struct packed {
        logic [CLA_GRP_W-1:0] g;
        logic [CLA_GRP_W-1:0] p;
    } cla_gp_t;

    // Returns carries into bits 1..3 in [2:0] and the group carry-out in [3].
    function automatic logic [CLA_GRP_W-1:0] cla_grp_carry(input cla_gp_t gp, input logic cin);
        logic [CLA_GRP_W-1:0] c;
        c[0] = gp.g[0] | (gp.p[0] & cin);
        c[1] = gp.g[1] | (gp.p[1] & gp.g[0]) | (gp.p[1] & gp.p[0] & cin);
        c[2] = gp.g[2] | (gp.p[2] & gp.g[1]) | (gp.p[2] & gp.p[1] & gp.g[0])
             | (gp.p[2] & gp.p[1] & gp.p[0] & cin);
        c[3] = gp.g[3] | (gp.p[3] & gp.g[2]) | (gp.p[3] & gp.p[2] & gp.g[1])
             | (gp.p[3] & gp.p[2] & gp.p[1] & gp.g[0])
             | (gp.p[3] & gp.p[2] & gp.p[1] & gp.p[0] & cin);
        return c;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// rtl/cla_pipe_adder_if.sv - operand/result stream bundle; in_sat exists only with CLA_PIPE_SAT_EN
interface cla_pipe_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
`ifdef CLA_PIPE_SAT_EN
    logic             in_sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub,
`ifdef CLA_PIPE_SAT_EN
        output in_sat,
`endif
        output out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub,
`ifdef CLA_PIPE_SAT_EN
        input  in_sat,
`endif
        input  out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - combinational 4-bit generate/propagate lookahead group
module cla_group4
    import cla_pkg::*;
(
    input  logic [CLA_GRP_W-1:0] a,
    input  logic [CLA_GRP_W-1:0] b,
    input  logic                 cin,
    output logic [CLA_GRP_W-1:0] s,
    output logic                 cout,
    output logic                 c3
);
    cla_gp_t              gp;
    logic [CLA_GRP_W-1:0] c;

    assign gp.g = a & b;
    assign gp.p = a ^ b;
    assign c    = cla_grp_carry(gp, cin);
    assign s    = gp.p ^ {c[2:0], cin};
    assign cout = c[3];
    assign c3   = c[2];
endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined CLA add/sub, one 4-bit group per stage; CLA_PIPE_SAT_EN adds saturation
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_pipe_adder_if.slave  bus
);
    localparam int NGRP = WIDTH / CLA_GRP_W;

    if ((WIDTH % CLA_GRP_W) != 0 || WIDTH < CLA_GRP_W) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a positive multiple of 4");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [WIDTH-1:0] st_a   [NGRP];
    logic [WIDTH-1:0] st_b   [NGRP];
    logic [WIDTH-1:0] st_sum [NGRP];
    logic             st_c   [NGRP];
    logic             st_v   [NGRP];
    logic [WIDTH-1:0] nxt_a   [NGRP];
    logic [WIDTH-1:0] nxt_b   [NGRP];
    logic [WIDTH-1:0] nxt_sum [NGRP];
    logic             nxt_c   [NGRP];
    logic             nxt_v   [NGRP];
`ifdef CLA_PIPE_SAT_EN
    logic             st_sat  [NGRP];
    logic             nxt_sat [NGRP];
`endif

    logic out_cout_q, out_ovf_q, out_zero_q;
    logic nxt_cout, nxt_ovf, nxt_zero;

    // The whole pipe moves as one; in_ready never looks at in_valid.
    assign adv          = !st_v[NGRP-1] || bus.out_ready;
    assign bus.in_ready = adv;
    assign b_eff        = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign cin_eff      = bus.in_sub | bus.in_cin;

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        logic [WIDTH-1:0]     p_a, p_b, p_sum, sum_k;
        logic                 p_c, p_v;
        logic [CLA_GRP_W-1:0] s;
        logic                 co, c3;
`ifdef CLA_PIPE_SAT_EN
        logic                 p_sat;
`endif

        if (k == 0) begin : g_src
            assign p_a   = bus.in_a;
            assign p_b   = b_eff;
            assign p_sum = '0;
            assign p_c   = cin_eff;
            assign p_v   = bus.in_valid;
`ifdef CLA_PIPE_SAT_EN
            assign p_sat = bus.in_sat;
`endif
        end else begin : g_src
            assign p_a   = st_a[k-1];
            assign p_b   = st_b[k-1];
            assign p_sum = st_sum[k-1];
            assign p_c   = st_c[k-1];
            assign p_v   = st_v[k-1];
`ifdef CLA_PIPE_SAT_EN
            assign p_sat = st_sat[k-1];
`endif
        end

        cla_group4 u_grp (
            .a    (p_a[k*CLA_GRP_W +: CLA_GRP_W]),
            .b    (p_b[k*CLA_GRP_W +: CLA_GRP_W]),
            .cin  (p_c),
            .s    (s),
            .cout (co),
            .c3   (c3)
        );

        always_comb begin
            sum_k = p_sum;
            sum_k[k*CLA_GRP_W +: CLA_GRP_W] = s;
        end

        assign nxt_a[k] = p_a;
        assign nxt_b[k] = p_b;
        assign nxt_c[k] = co;
        assign nxt_v[k] = p_v;
`ifdef CLA_PIPE_SAT_EN
        assign nxt_sat[k] = p_sat;
`endif

        if (k == NGRP - 1) begin : g_last
            logic             ovf;
            logic [WIDTH-1:0] res;

            assign ovf = c3 ^ co;
`ifdef CLA_PIPE_SAT_EN
            // A wrapped MSB of 1 means the true result overflowed positive.
            always_comb begin
                res = sum_k;
                if (p_sat && ovf) begin
                    res = sum_k[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
                end
            end
`else
            assign res = sum_k;
`endif
            assign nxt_sum[k] = res;
            assign nxt_cout   = co;
            assign nxt_ovf    = ovf;
            assign nxt_zero   = (res == '0);
        end else begin : g_mid
            assign nxt_sum[k] = sum_k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NGRP; k++) begin
                st_a[k]   <= '0;
                st_b[k]   <= '0;
                st_sum[k] <= '0;
                st_c[k]   <= 1'b0;
                st_v[k]   <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
                st_sat[k] <= 1'b0;
`endif
            end
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NGRP; k++) begin
                st_a[k]   <= nxt_a[k];
                st_b[k]   <= nxt_b[k];
                st_sum[k] <= nxt_sum[k];
                st_c[k]   <= nxt_c[k];
                st_v[k]   <= nxt_v[k];
`ifdef CLA_PIPE_SAT_EN
                st_sat[k] <= nxt_sat[k];
`endif
            end
            out_cout_q <= nxt_cout;
            out_ovf_q  <= nxt_ovf;
            out_zero_q <= nxt_zero;
        end
    end

    assign bus.out_valid = st_v[NGRP-1];
    assign bus.out_sum   = st_sum[NGRP-1];
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_zero  = out_zero_q;
endmodule
